// File: rtl/ama_riscv_imm_gen_pipe_pkg.sv
// Shared defines for the immediate generator: DFF macros, format select,
// queue state encoding and the generic immediate decode function.

`ifndef AMA_RISCV_DFF_MACROS
`define AMA_RISCV_DFF_MACROS
// Plain flop with synchronous active-high reset.
`define DFF_RST(CLK, RST, RV, D, Q) \
  always_ff @(posedge CLK) begin \
    if (RST) Q <= RV; \
    else Q <= D; \
  end
// Flop with load enable and synchronous active-high reset.
`define DFF_EN_RST(CLK, RST, EN, RV, D, Q) \
  always_ff @(posedge CLK) begin \
    if (RST) Q <= RV; \
    else if (EN) Q <= D; \
  end
`endif

package ama_riscv_imm_gen_pipe_pkg;

  // Immediate format select; IG_Z_TYPE appended after the original encodings.
  typedef enum logic [2:0] {
    IG_DISABLED = 3'd0,
    IG_I_TYPE   = 3'd1,
    IG_S_TYPE   = 3'd2,
    IG_B_TYPE   = 3'd3,
    IG_J_TYPE   = 3'd4,
    IG_U_TYPE   = 3'd5,
    IG_Z_TYPE   = 3'd6
  } ig_sel_t;

  // Occupancy of the 2-entry result queue.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_HALF  = 2'd1,
    Q_FULL  = 2'd2
  } ig_q_state_t;

  // Decodes at the widest supported XLEN; callers truncate to their width.
  // Sign extension is already replicated to bit 63, so truncation keeps it.
  // IG_DISABLED decodes to zero here; the caller substitutes its held value.
  function automatic logic [63:0] imm_decode(input ig_sel_t   sel,
                                             input logic [31:7] d,
                                             input logic        en_z);
    logic [63:0] imm;
    imm = '0;
    case (sel)
      IG_I_TYPE: imm = {{52{d[31]}}, d[31:20]};
      IG_S_TYPE: imm = {{52{d[31]}}, d[31:25], d[11:7]};
      IG_B_TYPE: imm = {{52{d[31]}}, d[7], d[30:25], d[11:8], 1'b0};
      IG_J_TYPE: imm = {{44{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
      IG_U_TYPE: imm = {{32{d[31]}}, d[31:12], 12'h000};
      IG_Z_TYPE: imm = en_z ? {59'd0, d[19:15]} : 64'd0;
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/ama_riscv_skid_buf.sv
// Two-entry in-order result queue (EMPTY/HALF/FULL). Head entry is always
// presented on o_head; it keeps its last value when the queue drains.

module ama_riscv_skid_buf
  import ama_riscv_imm_gen_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  output ig_q_state_t   o_state,
  output logic [W-1:0]  o_head
);

  // Handshake: i_push/i_pop are already qualified by the owner (valid &&
  // ready); a push in FULL or a pop in EMPTY is ignored. Flush wins over both.

  ig_q_state_t r_state;
  ig_q_state_t w_state_nxt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [W-1:0] w_head_d;
  logic         w_head_we;
  logic         w_tail_we;

  // Next-state and entry write enables.
  always_comb begin
    w_state_nxt = r_state;
    w_head_we   = 1'b0;
    w_head_d    = i_push_data;
    w_tail_we   = 1'b0;
    if (i_flush) begin
      w_state_nxt = Q_EMPTY;
    end else begin
      case (r_state)
        Q_EMPTY: begin
          if (i_push) begin
            w_head_we   = 1'b1;
            w_state_nxt = Q_HALF;
          end
        end
        Q_HALF: begin
          if (i_push && i_pop) begin
            // Old head leaves, new entry becomes head immediately.
            w_head_we = 1'b1;
          end else if (i_push) begin
            w_tail_we   = 1'b1;
            w_state_nxt = Q_FULL;
          end else if (i_pop) begin
            w_state_nxt = Q_EMPTY;
          end
        end
        Q_FULL: begin
          if (i_pop) begin
            w_head_we   = 1'b1;
            w_head_d    = r_tail;
            w_state_nxt = Q_HALF;
          end
        end
        default: w_state_nxt = Q_EMPTY;
      endcase
    end
  end

  // Queue state register.
  `DFF_RST(clk, rst, Q_EMPTY, w_state_nxt, r_state)

  // Head entry, drives the output.
  `DFF_EN_RST(clk, rst, w_head_we, '0, w_head_d, r_head)

  // Second entry, only written when HALF fills to FULL.
  `DFF_EN_RST(clk, rst, w_tail_we, '0, i_push_data, r_tail)

  assign o_state = r_state;
  assign o_head  = r_head;

endmodule

// File: rtl/ama_riscv_imm_gen_pipe.sv
// Pipelined immediate generator: decodes the immediate of an accepted
// request, remembers the last real immediate for IG_DISABLED requests, and
// queues results in a 2-entry buffer with valid/ready on both sides.

module ama_riscv_imm_gen_pipe
  import ama_riscv_imm_gen_pipe_pkg::*;
#(
  parameter int   XLEN     = 32,   // 32 or 64 only
  parameter logic EN_ZTYPE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  ig_sel_t         sel_in,
  input  logic [31:7]     d_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] d_out
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high and flush is low. in_ready depends only on registered queue
  // state and rst, never on out_ready; out_valid/d_out hold under stall.

  ig_q_state_t     w_q_state;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_push_data;
  logic [XLEN-1:0] r_last_imm;
  logic            w_is_dis;
  logic            w_push;
  logic            w_pop;
  logic            w_last_en;

  assign in_ready  = !rst && (w_q_state != Q_FULL);
  assign out_valid = (w_q_state != Q_EMPTY);

  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign w_imm       = XLEN'(imm_decode(sel_in, d_in, EN_ZTYPE));
  assign w_is_dis    = (sel_in == IG_DISABLED);
  assign w_push_data = w_is_dis ? r_last_imm : w_imm;
  assign w_last_en   = w_push && !w_is_dis;

  // Last immediate produced by an accepted non-disabled request.
  `DFF_EN_RST(clk, rst, w_last_en, '0, w_imm, r_last_imm)

  ama_riscv_skid_buf #(
    .W (XLEN)
  ) u_skid_buf (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_state     (w_q_state),
    .o_head      (d_out)
  );

endmodule

// File: tb/tb_ama_riscv_imm_gen_pipe.sv
// Directed bench for ama_riscv_imm_gen_pipe: XLEN=32, XLEN=64 and a
// Z-type-disabled copy share one stimulus stream.

module tb_ama_riscv_imm_gen_pipe;
  import ama_riscv_imm_gen_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  ig_sel_t     sel_in;
  logic [31:7] d_in;

  logic        in_ready32, out_valid32;
  logic [31:0] d_out32;
  logic        in_ready64, out_valid64;
  logic [63:0] d_out64;
  logic        in_readynz, out_validnz;
  logic [31:0] d_outnz;

  int n_cmp = 0;
  int n_err = 0;

  ama_riscv_imm_gen_pipe #(.XLEN(32), .EN_ZTYPE(1'b1)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .sel_in(sel_in), .d_in(d_in),
    .out_valid(out_valid32), .out_ready(out_ready), .d_out(d_out32)
  );

  ama_riscv_imm_gen_pipe #(.XLEN(64), .EN_ZTYPE(1'b1)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .sel_in(sel_in), .d_in(d_in),
    .out_valid(out_valid64), .out_ready(out_ready), .d_out(d_out64)
  );

  ama_riscv_imm_gen_pipe #(.XLEN(32), .EN_ZTYPE(1'b0)) unz (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_readynz), .sel_in(sel_in), .d_in(d_in),
    .out_valid(out_validnz), .out_ready(out_ready), .d_out(d_outnz)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input ig_sel_t s, input logic [31:0] instr);
    logic [31:0] t;
    t        = instr;
    in_valid = 1'b1;
    sel_in   = s;
    d_in     = t[31:7];
  endtask

  task automatic idle();
    in_valid = 1'b0;
    sel_in   = IG_DISABLED;
    d_in     = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp_v);
    end
  endtask

  // Immediate on both widths; exp64 is the full sign/zero-extended value.
  task automatic chk_imm(input string tag, input logic [63:0] exp64);
    chk({tag, "/d32"}, {32'd0, d_out32}, {32'd0, exp64[31:0]});
    chk({tag, "/d64"}, d_out64, exp64);
  endtask

  task automatic chk_ov(input string tag, input logic exp_v);
    chk({tag, "/ov32"}, {63'd0, out_valid32}, {63'd0, exp_v});
    chk({tag, "/ov64"}, {63'd0, out_valid64}, {63'd0, exp_v});
  endtask

  task automatic chk_ir(input string tag, input logic exp_v);
    chk({tag, "/ir32"}, {63'd0, in_ready32}, {63'd0, exp_v});
    chk({tag, "/ir64"}, {63'd0, in_ready64}, {63'd0, exp_v});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    idle();

    // Reset state
    tick();
    chk_ir("rst", 1'b0);
    chk_ov("rst", 1'b0);
    chk_imm("rst", 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk_ir("rel", 1'b1);

    // I-type all-ones immediate, latency 1
    req(IG_I_TYPE, 32'hFFF00093);
    tick();
    idle();
    chk_ov("itype", 1'b1);
    chk_imm("itype", 64'hFFFFFFFF_FFFFFFFF);

    // U-type, pushed while the I result pops (push+pop in HALF)
    req(IG_U_TYPE, 32'h800000B7);
    tick();
    chk_ov("utype", 1'b1);
    chk_imm("utype", 64'hFFFFFFFF_80000000);

    // B-type -4, then a disabled request returns the same value
    req(IG_B_TYPE, 32'hFE000EE3);
    tick();
    chk_imm("btype", 64'hFFFFFFFF_FFFFFFFC);
    req(IG_DISABLED, 32'h5A5A5A80);
    tick();
    idle();
    chk_ov("dis", 1'b1);
    chk_imm("dis", 64'hFFFFFFFF_FFFFFFFC);
    tick();
    chk_ov("drain", 1'b0);
    chk_imm("drain_hold", 64'hFFFFFFFF_FFFFFFFC);

    // S-type -8, J-type +2048, positive I-type 0x7FF
    req(IG_S_TYPE, 32'hFE000C23);
    tick();
    chk_imm("stype", 64'hFFFFFFFF_FFFFFFF8);
    req(IG_J_TYPE, 32'h0010006F);
    tick();
    chk_imm("jtype", 64'h0000_0000_0000_0800);
    req(IG_I_TYPE, 32'h7FF00093);
    tick();
    idle();
    chk_imm("ipos", 64'h0000_0000_0000_07FF);
    tick();
    chk_ov("empty1", 1'b0);

    // Backpressure: three requests with out_ready low
    out_ready = 1'b0;
    req(IG_I_TYPE, 32'h00100093);
    #1;
    chk_ir("bp_a_pre", 1'b1);
    tick();
    chk_ov("bp_a", 1'b1);
    chk_imm("bp_a", 64'h1);
    chk_ir("bp_a", 1'b1);
    req(IG_I_TYPE, 32'h00200093);
    tick();
    chk_ir("bp_full", 1'b0);
    chk_imm("bp_full", 64'h1);
    req(IG_I_TYPE, 32'h00300093);
    tick();
    chk_ir("bp_hold1", 1'b0);
    chk_ov("bp_hold1", 1'b1);
    chk_imm("bp_hold1", 64'h1);
    tick();
    chk_imm("bp_hold2", 64'h1);
    out_ready = 1'b1;
    tick();
    chk_imm("bp_drain2", 64'h2);
    chk_ir("bp_drain2", 1'b1);
    tick();
    idle();
    chk_imm("bp_drain3", 64'h3);
    tick();
    chk_ov("bp_empty", 1'b0);

    // Z-type zimm; the EN_ZTYPE=0 copy yields zero
    req(IG_Z_TYPE, 32'hABCF8073);
    tick();
    idle();
    chk_imm("ztype", 64'h1F);
    chk("ztype/nz", {32'd0, d_outnz}, 64'h0);
    tick();

    // Flush with a FULL queue
    out_ready = 1'b0;
    req(IG_I_TYPE, 32'h00500093);
    tick();
    req(IG_I_TYPE, 32'h00600093);
    tick();
    idle();
    chk_ir("fl_full", 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_ov("fl", 1'b0);
    chk_ir("fl", 1'b1);
    chk_imm("fl_hold", 64'h5);

    // Flush discards a same-cycle request and leaves last_imm alone
    req(IG_I_TYPE, 32'h00900093);
    tick();
    chk_imm("fl_push9", 64'h9);
    req(IG_I_TYPE, 32'h07700093);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_ov("fl_req", 1'b0);
    out_ready = 1'b1;
    req(IG_DISABLED, 32'h0);
    tick();
    idle();
    chk_ov("fl_last", 1'b1);
    chk_imm("fl_last", 64'h9);
    tick();
    chk_ov("empty2", 1'b0);

    // Reset while FULL, with flush and a request also present
    out_ready = 1'b0;
    req(IG_I_TYPE, 32'h01100093);
    tick();
    req(IG_I_TYPE, 32'h01200093);
    tick();
    chk_ir("rf_full", 1'b0);
    req(IG_I_TYPE, 32'h01300093);
    rst = 1'b1;
    flush = 1'b1;
    #1;
    chk_ir("rf_in_rst", 1'b0);
    tick();
    chk_ov("rf_rst", 1'b0);
    chk_imm("rf_rst", 64'h0);
    chk_ir("rf_rst", 1'b0);
    rst = 1'b0;
    flush = 1'b0;
    idle();
    #1;
    chk_ir("rf_rel", 1'b1);

    // last_imm cleared by reset
    out_ready = 1'b1;
    req(IG_DISABLED, 32'h0);
    tick();
    idle();
    chk_ov("rf_last", 1'b1);
    chk_imm("rf_last", 64'h0);
    tick();
    chk_ov("empty3", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ama_riscv_imm_gen_pipe.md
AMA_RISCV_IMM_GEN_PIPE -- requirements
Module: ama_riscv_imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter EN_ZTYPE, 1, enables IG_Z_TYPE (CSR zimm) decode; when 0, IG_Z_TYPE yields 0.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port flush  in  1  drops all buffered results.
REQ-006 SHALL have port in_valid  in  1  upstream request valid.
REQ-007 SHALL have port in_ready  out  1  block accepts request this cycle.
REQ-008 SHALL have port sel_in  in  ig_sel_t  format select.
REQ-009 SHALL have port d_in  in  25 ([31:7])  instruction bits.
REQ-010 SHALL have port out_valid  out  1  d_out holds a result.
REQ-011 SHALL have port out_ready  in  1  downstream consumes result.
REQ-012 SHALL have port d_out  out  XLEN  generated immediate.

Function
REQ-013 SHALL decode I, S, B, J, U per RISC-V base ISA; I/S/B/J sign-extended from d_in[31] to XLEN; B/J bit 0 = 0.
REQ-014 SHALL produce U-type as {d_in[31:12], 12'h0} sign-extended from d_in[31] to XLEN (RV64 LUI semantics).
REQ-015 SHALL produce IG_Z_TYPE as d_in[19:15] zero-extended to XLEN.
REQ-016 SHALL, for an accepted IG_DISABLED request, produce the last immediate generated by a non-disabled accepted request (held register, "last_imm").
REQ-017 SHALL update last_imm only on acceptance (in_valid && in_ready && !flush) of a non-disabled request.
REQ-018 SHALL buffer results in a 2-entry in-order queue with states EMPTY, HALF, FULL.
REQ-019 SHALL assert in_ready = !rst && state != FULL, driven from registered state only (no combinational path from out_ready).
REQ-020 SHALL have latency 1: request accepted in cycle N gives out_valid=1 with its d_out in cycle N+1 if queue was EMPTY.
REQ-021 SHALL set out_valid = (state != EMPTY); d_out = head entry; d_out and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL transition: EMPTY+push->HALF; HALF+push-only->FULL; HALF+pop-only->EMPTY; HALF+push+pop->HALF; FULL+pop->HALF; FULL ignores in_valid.
REQ-023 SHALL, on simultaneous push and pop in HALF, output the new entry in the next cycle.
REQ-024 SHALL, with flush=1, go to EMPTY next cycle, discard the same-cycle request and not update last_imm; flush takes priority over push/pop.
REQ-025 SHALL keep d_out at its previous value when the queue becomes EMPTY (no X, no zeroing).

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set state EMPTY, out_valid 0, d_out 0, last_imm 0, both queue entries 0.
REQ-027 SHALL hold in_ready 0 while rst=1; reset mid-transfer discards all entries and takes priority over flush and push.

Structure
REQ-028 SHALL extend ig_sel_t in the shared defines package with IG_Z_TYPE; existing encodings unchanged.
REQ-029 SHALL place a generic XLEN-wide immediate decode function in the shared package.
REQ-030 SHALL implement the queue as sub-module ama_riscv_skid_buf (parameter W), instantiated with W=XLEN.
REQ-031 SHALL use the codebase's DFF macros for all state; no latches, no async reset.

Verification
REQ-032 SHALL cover: XLEN=64, I-type instr 0xFFF00093, out_ready=1 -> next cycle d_out=0xFFFFFFFF_FFFFFFFF, out_valid=1.
REQ-033 SHALL cover: XLEN=64, U-type 0x800000B7 -> d_out=0xFFFFFFFF_80000000; XLEN=32 -> 0x80000000.
REQ-034 SHALL cover: B-type 0xFE000EE3 then IG_DISABLED request -> d_out 0xFFFFFFFC (XLEN=32) on both results.
REQ-035 SHALL cover: out_ready=0, three back-to-back requests -> in_ready drops after second accept, third held; out_ready=1 drains in order.
REQ-036 SHALL cover: Z-type d_in[19:15]=5'h1F -> d_out=0x1F; flush with FULL queue -> out_valid 0 next cycle, last_imm unchanged.
REQ-037 SHALL cover: rst asserted while FULL -> out_valid 0, d_out 0, in_ready 0 during reset, 1 the cycle after release.
